// File: rtl/word_symbol_tx.sv
// Transmit sequencer for the {tom,in1,in2,in3}/ok word-symbol interface.
// Emits stem letters, class suffix and terminator with valid/ready and gaps.
module word_symbol_tx #(
   parameter int GAP = 1,
   parameter int CW  = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] kind,
   input  logic [3:0] stem0,
   input  logic [3:0] stem1,
   input  logic       ready,
   input  logic       abort,
   output logic       ok,
   output logic       tom,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       exp_out1,
   output logic       exp_out2
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic [2:0]      idx, idx_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [3:0]      sym, sym_n;
   logic [2:0]      kind_q, kind_n;
   logic [3:0]      s0_q, s0_n;
   logic [3:0]      s1_q, s1_n;
   logic            e1_q, e1_n;
   logic            e2_q, e2_n;
   logic            err_q, err_n;
   logic            req_ok;
   logic            last;

   function automatic logic [3:0] sym_of(
      input logic [2:0] k,
      input logic [2:0] i,
      input logic [3:0] a,
      input logic [3:0] b
   );
      logic [3:0] r;
      r = 4'b0000;
      case (i)
         3'd0: r = a;
         3'd1: r = b;
         3'd2: r = (k == 3'd1 || k == 3'd4) ? 4'b0111 : 4'b0110;
         3'd3: begin
            case (k)
               3'd2:    r = 4'b0111;
               3'd3:    r = 4'b1001;
               3'd4:    r = 4'b1010;
               default: r = 4'b0000;
            endcase
         end
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   // A stem with zero letter bits would be indistinguishable from a terminator.
   assign req_ok = (kind <= 3'd4) && (stem0[2:0] != 3'b000)
                   && (stem1[2:0] != 3'b000);
   assign last   = (kind_q <= 3'd1) ? (idx == 3'd3) : (idx == 3'd4);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      sym_n   = sym;
      kind_n  = kind_q;
      s0_n    = s0_q;
      s1_n    = s1_q;
      e1_n    = e1_q;
      e2_n    = e2_q;
      err_n   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (req_ok) begin
                  kind_n  = kind;
                  s0_n    = stem0;
                  s1_n    = stem1;
                  e1_n    = (kind >= 3'd2);
                  e2_n    = (kind <= 3'd2);
                  idx_n   = 3'd0;
                  sym_n   = stem0;
                  state_n = S_SEND;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         S_SEND: begin
            if (abort) begin
               state_n = S_IDLE;
               sym_n   = 4'b0000;
               idx_n   = 3'd0;
               err_n   = 1'b1;
            end else if (ready) begin
               if (last) begin
                  state_n = S_DONE;
               end else begin
                  idx_n = idx + 3'd1;
                  if (GAP == 0) begin
                     sym_n = sym_of(kind_q, idx + 3'd1, s0_q, s1_q);
                  end else begin
                     state_n = S_GAP;
                     cnt_n   = CW'(GAP);
                  end
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_n = S_IDLE;
               sym_n   = 4'b0000;
               idx_n   = 3'd0;
               cnt_n   = '0;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state_n = S_SEND;
                  sym_n   = sym_of(kind_q, idx, s0_q, s1_q);
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            idx_n   = 3'd0;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         idx    <= 3'd0;
         cnt    <= '0;
         sym    <= 4'b0000;
         kind_q <= 3'd0;
         s0_q   <= 4'b0000;
         s1_q   <= 4'b0000;
         e1_q   <= 1'b0;
         e2_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         idx    <= idx_n;
         cnt    <= cnt_n;
         sym    <= sym_n;
         kind_q <= kind_n;
         s0_q   <= s0_n;
         s1_q   <= s1_n;
         e1_q   <= e1_n;
         e2_q   <= e2_n;
         err_q  <= err_n;
      end
   end

   assign ok       = (state == S_SEND);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign err      = err_q;
   assign {tom, in1, in2, in3} = sym;
   assign exp_out1 = e1_q;
   assign exp_out2 = e2_q;

endmodule

// File: tb/tb_word_symbol_tx.sv
// Directed bench for word_symbol_tx: one instance with GAP=1, one with GAP=0.
// Both share stimulus; each scenario checks the instance it targets.
module tb_word_symbol_tx;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] kind;
   logic [3:0] stem0;
   logic [3:0] stem1;
   logic       ready;
   logic       abort;

   logic ok, tom, in1, in2, in3, busy, done, err, eo1, eo2;
   logic ok0, tom0, in10, in20, in30, busy0, done0, err0, eo10, eo20;
   logic [3:0] sy, sy0;

   int total = 0;
   int bad   = 0;

   assign sy  = {tom, in1, in2, in3};
   assign sy0 = {tom0, in10, in20, in30};

   always #5 clock = ~clock;

   word_symbol_tx #(.GAP(1), .CW(4)) dut (
      .clock(clock), .reset(reset), .start(start), .kind(kind),
      .stem0(stem0), .stem1(stem1), .ready(ready), .abort(abort),
      .ok(ok), .tom(tom), .in1(in1), .in2(in2), .in3(in3),
      .busy(busy), .done(done), .err(err),
      .exp_out1(eo1), .exp_out2(eo2)
   );

   word_symbol_tx #(.GAP(0), .CW(4)) dut0 (
      .clock(clock), .reset(reset), .start(start), .kind(kind),
      .stem0(stem0), .stem1(stem1), .ready(ready), .abort(abort),
      .ok(ok0), .tom(tom0), .in1(in10), .in2(in20), .in3(in30),
      .busy(busy0), .done(done0), .err(err0),
      .exp_out1(eo10), .exp_out2(eo20)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_both();
      for (int i = 0; i < 60; i++) begin
         if (!busy && !busy0) break;
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      kind  = 3'd0;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      ready = 1'b1;
      abort = 1'b0;
      tick();
      tick();
      total++;
      if ({ok, busy, done, err, sy, eo1, eo2} !== 10'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b want=0000000000",
                  {ok, busy, done, err, sy, eo1, eo2});
      end
      total++;
      if ({ok0, busy0, done0, err0} !== 4'b0) begin
         bad++;
         $display("FAIL reset_outs0 got=%b want=0000",
                  {ok0, busy0, done0, err0});
      end
      start = 1'b0;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_gap1();
      logic [3:0] e [4];
      int k;
      e[0] = 4'b0011;
      e[1] = 4'b0101;
      e[2] = 4'b0110;
      e[3] = 4'b0000;
      k = 0;
      kind  = 3'd0;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         logic wok;
         wok = (c == 1 || c == 3 || c == 5 || c == 7);
         total++;
         if (ok !== wok || busy !== (c <= 8) || done !== (c == 8)) begin
            bad++;
            $display("FAIL gap1_ctl cyc=%0d got ok/busy/done=%b%b%b want=%b%b%b",
                     c, ok, busy, done, wok, (c <= 8), (c == 8));
         end
         if (wok) begin
            total++;
            if (sy !== e[k]) begin
               bad++;
               $display("FAIL gap1_sym cyc=%0d got=%b want=%b", c, sy, e[k]);
            end
            k++;
         end
         tick();
      end
      total++;
      if ({eo1, eo2} !== 2'b01) begin
         bad++;
         $display("FAIL gap1_exp got=%b want=01", {eo1, eo2});
      end
      idle_both();
   endtask

   task automatic test_stall();
      logic [3:0] e [5];
      logic [3:0] got [8];
      int n, dn;
      e[0] = 4'b0011;
      e[1] = 4'b0101;
      e[2] = 4'b0110;
      e[3] = 4'b0111;
      e[4] = 4'b0000;
      kind  = 3'd2;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (ok !== 1'b1 || sy !== 4'b0011) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got ok=%b sym=%b want ok=1 sym=0011",
                     c, ok, sy);
         end
         if (c < 2) tick();
      end
      ready = 1'b1;
      n  = 0;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0 && !busy) break;
         if (ok) begin
            if (n < 8) got[n] = sy;
            n++;
         end
         if (done) dn++;
         tick();
      end
      total++;
      if (n !== 5 || dn !== 1) begin
         bad++;
         $display("FAIL stall_count got syms=%0d dones=%0d want 5 1", n, dn);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (got[i] !== e[i]) begin
            bad++;
            $display("FAIL stall_sym i=%0d got=%b want=%b", i, got[i], e[i]);
         end
      end
      total++;
      if ({eo1, eo2} !== 2'b11) begin
         bad++;
         $display("FAIL stall_exp got=%b want=11", {eo1, eo2});
      end
      idle_both();
   endtask

   task automatic test_nogap();
      logic [3:0] e [5];
      e[0] = 4'b0001;
      e[1] = 4'b0010;
      e[2] = 4'b0111;
      e[3] = 4'b1010;
      e[4] = 4'b0000;
      kind  = 3'd4;
      stem0 = 4'b0001;
      stem1 = 4'b0010;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         total++;
         if (ok0 !== (c <= 5) || done0 !== (c == 6)) begin
            bad++;
            $display("FAIL nogap_ctl cyc=%0d got ok/done=%b%b want=%b%b",
                     c, ok0, done0, (c <= 5), (c == 6));
         end
         if (c <= 5) begin
            total++;
            if (sy0 !== e[c-1]) begin
               bad++;
               $display("FAIL nogap_sym cyc=%0d got=%b want=%b", c, sy0, e[c-1]);
            end
         end
         tick();
      end
      total++;
      if ({eo10, eo20} !== 2'b10) begin
         bad++;
         $display("FAIL nogap_exp got=%b want=10", {eo10, eo20});
      end
      idle_both();
   endtask

   task automatic test_reject();
      kind  = 3'd6;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || ok !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rej_kind got err/ok/busy=%b%b%b want=100", err, ok, busy);
      end
      tick();
      total++;
      if (err !== 1'b0 || ok !== 1'b0) begin
         bad++;
         $display("FAIL rej_pulse got err/ok=%b%b want=00", err, ok);
      end
      kind  = 3'd1;
      stem1 = 4'b1000;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || {eo1, eo2} !== 2'b10) begin
         bad++;
         $display("FAIL rej_stem got err/busy/exp=%b%b%b want=1010",
                  err, busy, {eo1, eo2});
      end
      tick();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rej_stem_after got err/busy=%b%b want=00", err, busy);
      end
   endtask

   task automatic test_abort();
      logic [3:0] e [4];
      int n, dn;
      kind  = 3'd3;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (ok !== 1'b1 || sy !== 4'b0110) begin
         bad++;
         $display("FAIL abort_pre got ok=%b sym=%b want ok=1 sym=0110", ok, sy);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (ok !== 1'b0 || sy !== 4'b0000 || err !== 1'b1 || busy !== 1'b0
          || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_post got ok=%b sym=%b err=%b busy=%b done=%b",
                  ok, sy, err, busy, done);
      end
      tick();
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL abort_errpulse got=%b want=0", err);
      end
      e[0] = 4'b1001;
      e[1] = 4'b0010;
      e[2] = 4'b0110;
      e[3] = 4'b0000;
      kind  = 3'd0;
      stem0 = 4'b1001;
      stem1 = 4'b0010;
      start = 1'b1;
      tick();
      start = 1'b0;
      n  = 0;
      dn = 0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0 && !busy) break;
         if (ok) begin
            total++;
            if (n > 3 || sy !== e[n]) begin
               bad++;
               $display("FAIL abort_restart_sym i=%0d got=%b", n, sy);
            end
            n++;
         end
         if (done) dn++;
         tick();
      end
      total++;
      if (n !== 4 || dn !== 1) begin
         bad++;
         $display("FAIL abort_restart got syms=%0d dones=%0d want 4 1", n, dn);
      end
      idle_both();
   endtask

   task automatic test_reset_mid();
      kind  = 3'd2;
      stem0 = 4'b0011;
      stem1 = 4'b0101;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++;
      if (ok !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rmid_gap got ok/busy=%b%b want=01", ok, busy);
      end
      reset = 1'b1;
      start = 1'b1;
      tick();
      total++;
      if ({ok, busy, done, err, sy, eo1, eo2} !== 10'b0) begin
         bad++;
         $display("FAIL rmid_outs got=%b want=0000000000",
                  {ok, busy, done, err, sy, eo1, eo2});
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || ok !== 1'b0) begin
         bad++;
         $display("FAIL rmid_nostart got busy/ok=%b%b want=00", busy, ok);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      kind  = 3'd0;
      stem0 = 4'b0;
      stem1 = 4'b0;
      ready = 1'b1;
      abort = 1'b0;
      test_reset();
      test_gap1();
      test_stall();
      test_nogap();
      test_reject();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
